// File: rtl/kronos_wb_arbiter_if.sv
// rtl/kronos_wb_arbiter_if.sv - write-back requester, scoreboard and register-file port bundle
interface kronos_wb_arbiter_if;
  logic        ex_wb_vld;
  logic        ex_wb_rdy;
  logic [4:0]  ex_wb_sel;
  logic [31:0] ex_wb_data;

  logic        lsu_wb_vld;
  logic        lsu_wb_rdy;
  logic [4:0]  lsu_wb_sel;
  logic [31:0] lsu_wb_data;

  logic        dbg_wb_vld;
  logic        dbg_wb_rdy;
  logic [4:0]  dbg_wb_sel;
  logic [31:0] dbg_wb_data;

  logic        lsu_issue;
  logic [4:0]  lsu_issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        chk_rs1_busy;
  logic        chk_rs2_busy;

  logic        regwr_en;
  logic [4:0]  regwr_sel;
  logic [31:0] regwr_data;

  modport slave (
    input  ex_wb_vld, ex_wb_sel, ex_wb_data,
    input  lsu_wb_vld, lsu_wb_sel, lsu_wb_data,
    input  dbg_wb_vld, dbg_wb_sel, dbg_wb_data,
    input  lsu_issue, lsu_issue_rd, chk_rs1, chk_rs2,
    output ex_wb_rdy, lsu_wb_rdy, dbg_wb_rdy,
    output chk_rs1_busy, chk_rs2_busy,
    output regwr_en, regwr_sel, regwr_data
  );

  modport master (
    output ex_wb_vld, ex_wb_sel, ex_wb_data,
    output lsu_wb_vld, lsu_wb_sel, lsu_wb_data,
    output dbg_wb_vld, dbg_wb_sel, dbg_wb_data,
    output lsu_issue, lsu_issue_rd, chk_rs1, chk_rs2,
    input  ex_wb_rdy, lsu_wb_rdy, dbg_wb_rdy,
    input  chk_rs1_busy, chk_rs2_busy,
    input  regwr_en, regwr_sel, regwr_data
  );
endinterface

// File: rtl/kronos_wb_arbiter.sv
// rtl/kronos_wb_arbiter.sv - register-file write-port arbiter (EX/LSU round-robin, DBG lowest) with load scoreboard
module kronos_wb_arbiter #(
  parameter bit DBG_EN = 1'b1
) (
  input logic clk,
  input logic rstz,
  kronos_wb_arbiter_if.slave wb
);

  logic        prio_q, prio_d;
  logic [31:0] busy_q, busy_d;
  logic        regwr_en_q, regwr_en_d;
  logic [4:0]  regwr_sel_q, regwr_sel_d;
  logic [31:0] regwr_data_q, regwr_data_d;
  logic        gnt_ex, gnt_lsu, gnt_dbg;

  // Grants are gated by rstz so no requester sees a transfer while reset is held.
  always_comb begin
    gnt_ex  = 1'b0;
    gnt_lsu = 1'b0;
    gnt_dbg = 1'b0;
    if (rstz) begin
      if (wb.ex_wb_vld && wb.lsu_wb_vld) begin
        gnt_ex  = ~prio_q;
        gnt_lsu = prio_q;
      end else if (wb.ex_wb_vld) begin
        gnt_ex = 1'b1;
      end else if (wb.lsu_wb_vld) begin
        gnt_lsu = 1'b1;
      end else if (DBG_EN && wb.dbg_wb_vld) begin
        gnt_dbg = 1'b1;
      end
    end
  end

  assign wb.ex_wb_rdy  = gnt_ex;
  assign wb.lsu_wb_rdy = gnt_lsu;
  assign wb.dbg_wb_rdy = gnt_dbg;

  always_comb begin
    prio_d       = prio_q;
    regwr_en_d   = 1'b0;
    regwr_sel_d  = regwr_sel_q;
    regwr_data_d = regwr_data_q;
    if (gnt_ex) begin
      prio_d       = 1'b1;
      regwr_sel_d  = wb.ex_wb_sel;
      regwr_data_d = wb.ex_wb_data;
    end else if (gnt_lsu) begin
      prio_d       = 1'b0;
      regwr_sel_d  = wb.lsu_wb_sel;
      regwr_data_d = wb.lsu_wb_data;
    end else if (gnt_dbg) begin
      regwr_sel_d  = wb.dbg_wb_sel;
      regwr_data_d = wb.dbg_wb_data;
    end
    if (gnt_ex || gnt_lsu || gnt_dbg) begin
      regwr_en_d = (regwr_sel_d != 5'd0);
    end
  end

  // Set is applied after clear so a re-issue to the register being filled stays busy.
  always_comb begin
    busy_d = busy_q;
    if (gnt_lsu) begin
      busy_d[wb.lsu_wb_sel] = 1'b0;
    end
    if (wb.lsu_issue && (wb.lsu_issue_rd != 5'd0)) begin
      busy_d[wb.lsu_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      prio_q       <= 1'b0;
      busy_q       <= 32'd0;
      regwr_en_q   <= 1'b0;
      regwr_sel_q  <= 5'd0;
      regwr_data_q <= 32'd0;
    end else begin
      prio_q       <= prio_d;
      busy_q       <= busy_d;
      regwr_en_q   <= regwr_en_d;
      regwr_sel_q  <= regwr_sel_d;
      regwr_data_q <= regwr_data_d;
    end
  end

  assign wb.regwr_en     = regwr_en_q;
  assign wb.regwr_sel    = regwr_sel_q;
  assign wb.regwr_data   = regwr_data_q;
  assign wb.chk_rs1_busy = busy_q[wb.chk_rs1];
  assign wb.chk_rs2_busy = busy_q[wb.chk_rs2];

endmodule

// File: tb/tb_kronos_wb_arbiter.sv
// tb/tb_kronos_wb_arbiter.sv - scoreboard bench for kronos_wb_arbiter against a behavioural model
module tb_kronos_wb_arbiter;

  logic clk = 1'b0;
  logic rstz;
  always #5 clk = ~clk;

  kronos_wb_arbiter_if wb ();

  kronos_wb_arbiter #(.DBG_EN(1'b1)) dut (
    .clk  (clk),
    .rstz (rstz),
    .wb   (wb)
  );

  typedef struct {
    logic        en;
    logic [4:0]  sel;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: which of EX/LSU is owed the next tie, held write port, busy set
  bit          m_favour_lsu;
  bit          m_busy[32];
  logic [4:0]  m_sel;
  logic [31:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_favour_lsu = 1'b0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_sel  = 5'd0;
    m_data = 32'd0;
    q.delete();
  endtask

  // Evaluates one cycle: checks grants, predicts the write port and busy set, queues it.
  task automatic step(output int w);
    exp_t e;
    @(negedge clk);
    w = 0;
    if (wb.ex_wb_vld && wb.lsu_wb_vld) w = m_favour_lsu ? 2 : 1;
    else if (wb.ex_wb_vld)             w = 1;
    else if (wb.lsu_wb_vld)            w = 2;
    else if (wb.dbg_wb_vld)            w = 3;
    check("ex_wb_rdy",  32'(wb.ex_wb_rdy),  32'(w == 1));
    check("lsu_wb_rdy", 32'(wb.lsu_wb_rdy), 32'(w == 2));
    check("dbg_wb_rdy", 32'(wb.dbg_wb_rdy), 32'(w == 3));
    e.en = 1'b0;
    case (w)
      1: begin m_sel = wb.ex_wb_sel;  m_data = wb.ex_wb_data;  m_favour_lsu = 1'b1; end
      2: begin m_sel = wb.lsu_wb_sel; m_data = wb.lsu_wb_data; m_favour_lsu = 1'b0;
               m_busy[wb.lsu_wb_sel] = 1'b0; end
      3: begin m_sel = wb.dbg_wb_sel; m_data = wb.dbg_wb_data; end
      default: ;
    endcase
    if (w != 0) e.en = (m_sel != 5'd0);
    if (wb.lsu_issue && wb.lsu_issue_rd != 5'd0) m_busy[wb.lsu_issue_rd] = 1'b1;
    e.sel  = m_sel;
    e.data = m_data;
    for (int i = 0; i < 32; i++) e.mask[i] = (i == 0) ? 1'b0 : m_busy[i];
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rstz === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        check("regwr_en",     32'(wb.regwr_en),     32'(e.en));
        check("regwr_sel",    32'(wb.regwr_sel),    32'(e.sel));
        check("regwr_data",   wb.regwr_data,        e.data);
        check("chk_rs1_busy", 32'(wb.chk_rs1_busy), 32'(e.mask[wb.chk_rs1]));
        check("chk_rs2_busy", 32'(wb.chk_rs2_busy), 32'(e.mask[wb.chk_rs2]));
      end
    end
  end

  task automatic idle_inputs();
    wb.ex_wb_vld = 1'b0;  wb.ex_wb_sel = 5'd0;  wb.ex_wb_data = 32'd0;
    wb.lsu_wb_vld = 1'b0; wb.lsu_wb_sel = 5'd0; wb.lsu_wb_data = 32'd0;
    wb.dbg_wb_vld = 1'b0; wb.dbg_wb_sel = 5'd0; wb.dbg_wb_data = 32'd0;
    wb.lsu_issue = 1'b0;  wb.lsu_issue_rd = 5'd0;
    wb.chk_rs1 = 5'd0;    wb.chk_rs2 = 5'd0;
  endtask

  task automatic random_cycles(input int n);
    int w = 0;
    for (int c = 0; c < n; c++) begin
      if (!wb.ex_wb_vld || w == 1) begin
        wb.ex_wb_vld = 1'($urandom_range(0, 1)); wb.ex_wb_sel = 5'($urandom); wb.ex_wb_data = $urandom;
      end
      if (!wb.lsu_wb_vld || w == 2) begin
        wb.lsu_wb_vld = 1'($urandom_range(0, 1)); wb.lsu_wb_sel = 5'($urandom); wb.lsu_wb_data = $urandom;
      end
      if (!wb.dbg_wb_vld || w == 3) begin
        wb.dbg_wb_vld = ($urandom_range(0, 3) == 0); wb.dbg_wb_sel = 5'($urandom); wb.dbg_wb_data = $urandom;
      end
      wb.lsu_issue    = 1'($urandom_range(0, 1));
      wb.lsu_issue_rd = 5'($urandom);
      wb.chk_rs1      = 5'($urandom);
      wb.chk_rs2      = 5'($urandom);
      step(w);
    end
  endtask

  initial begin : stimulus
    int w;
    idle_inputs();
    model_reset();
    rstz = 1'b0;
    wb.ex_wb_vld = 1'b1; wb.lsu_wb_vld = 1'b1; wb.dbg_wb_vld = 1'b1;
    wb.chk_rs1 = 5'd7;   wb.chk_rs2 = 5'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ex_rdy",  32'(wb.ex_wb_rdy),  32'd0);
    check("rst_lsu_rdy", 32'(wb.lsu_wb_rdy), 32'd0);
    check("rst_dbg_rdy", 32'(wb.dbg_wb_rdy), 32'd0);
    check("rst_regwr_en",   32'(wb.regwr_en),   32'd0);
    check("rst_regwr_sel",  32'(wb.regwr_sel),  32'd0);
    check("rst_regwr_data", wb.regwr_data,      32'd0);
    check("rst_rs1_busy", 32'(wb.chk_rs1_busy), 32'd0);
    check("rst_rs2_busy", 32'(wb.chk_rs2_busy), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    rstz = 1'b1;

    // first write after reset
    wb.ex_wb_vld = 1'b1; wb.ex_wb_sel = 5'd5; wb.ex_wb_data = 32'hDEADBEEF;
    step(w);
    wb.ex_wb_vld = 1'b0;
    // an LSU grant returns the tie to EX before the contention run
    wb.lsu_wb_vld = 1'b1; wb.lsu_wb_sel = 5'd3; wb.lsu_wb_data = 32'h0000_0033;
    step(w);

    wb.ex_wb_vld = 1'b1; wb.ex_wb_sel = 5'd10; wb.ex_wb_data = 32'hE000_0000;
    wb.lsu_wb_vld = 1'b1; wb.lsu_wb_sel = 5'd11; wb.lsu_wb_data = 32'hA000_0000;
    for (int k = 0; k < 4; k++) begin
      step(w);
      if (w == 1) begin wb.ex_wb_sel = 5'(12 + k); wb.ex_wb_data = 32'hE000_0001 + k; end
      if (w == 2) begin wb.lsu_wb_sel = 5'(20 + k); wb.lsu_wb_data = 32'hA000_0001 + k; end
    end
    wb.lsu_wb_vld = 1'b0;

    // debug waits behind EX
    wb.dbg_wb_vld = 1'b1; wb.dbg_wb_sel = 5'd2; wb.dbg_wb_data = 32'h0D0D_0D0D;
    for (int k = 0; k < 2; k++) begin
      step(w);
      wb.ex_wb_sel = 5'(25 + k); wb.ex_wb_data = 32'h5000_0000 + k;
    end
    wb.ex_wb_vld = 1'b0;
    step(w);
    wb.dbg_wb_vld = 1'b0;

    // x0 write consumed without enable
    wb.ex_wb_vld = 1'b1; wb.ex_wb_sel = 5'd0; wb.ex_wb_data = 32'h0000_1234;
    step(w);
    wb.ex_wb_vld = 1'b0;
    step(w);

    // load scoreboard
    wb.chk_rs1 = 5'd7; wb.chk_rs2 = 5'd0;
    wb.lsu_issue = 1'b1; wb.lsu_issue_rd = 5'd7;
    step(w);
    wb.lsu_issue = 1'b0;
    step(w);
    wb.lsu_wb_vld = 1'b1; wb.lsu_wb_sel = 5'd7; wb.lsu_wb_data = 32'h7777_7777;
    step(w);
    wb.lsu_wb_vld = 1'b0;
    step(w);

    // same-cycle set and clear, then issue to x0
    wb.chk_rs1 = 5'd9;
    wb.lsu_issue = 1'b1; wb.lsu_issue_rd = 5'd9;
    step(w);
    wb.lsu_wb_vld = 1'b1; wb.lsu_wb_sel = 5'd9; wb.lsu_wb_data = 32'h9999_9999;
    step(w);
    wb.lsu_wb_vld = 1'b0; wb.lsu_issue_rd = 5'd0;
    step(w);
    wb.lsu_issue = 1'b0;
    step(w);

    random_cycles(400);

    // reset in the middle of traffic
    rstz = 1'b0;
    #3;
    check("midrst_ex_rdy",   32'(wb.ex_wb_rdy),  32'd0);
    check("midrst_lsu_rdy",  32'(wb.lsu_wb_rdy), 32'd0);
    check("midrst_dbg_rdy",  32'(wb.dbg_wb_rdy), 32'd0);
    check("midrst_regwr_en", 32'(wb.regwr_en),   32'd0);
    check("midrst_rs1_busy", 32'(wb.chk_rs1_busy), 32'd0);
    check("midrst_rs2_busy", 32'(wb.chk_rs2_busy), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rstz = 1'b1;
    random_cycles(400);

    idle_inputs();
    step(w);
    @(posedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kronos_wb_arbiter.md
# kronos_wb_arbiter

Write-back arbiter and load scoreboard for the Kronos integer register file. It shares the register file's single write port (regwr_en/regwr_sel/regwr_data) between three requesters: the execute stage, the load/store unit and the debug module. It also tracks destination registers of in-flight loads so decode can stall on true load-use hazards. It sits between the execute/LSU/debug blocks and the register file.

## Interface
Parameters:
- DBG_EN, default 1: enable the debug write requester; when 0, dbg_wb_rdy is tied 0.

Ports:
- clk  in  1  clock
- rstz  in  1  reset, asynchronous, active-low
- ex_wb_vld  in  1  execute result valid
- ex_wb_rdy  out  1  execute result accepted this cycle
- ex_wb_sel  in  5  execute destination register
- ex_wb_data  in  32  execute result
- lsu_wb_vld  in  1  load data valid
- lsu_wb_rdy  out  1  load data accepted
- lsu_wb_sel  in  5  load destination register
- lsu_wb_data  in  32  load data
- dbg_wb_vld  in  1  debug register write request
- dbg_wb_rdy  out  1  debug write accepted
- dbg_wb_sel  in  5  debug destination register
- dbg_wb_data  in  32  debug write data
- lsu_issue  in  1  load issued to memory (one-cycle pulse)
- lsu_issue_rd  in  5  destination of the issued load
- chk_rs1  in  5  decode source 1 to check
- chk_rs2  in  5  decode source 2 to check
- chk_rs1_busy  out  1  chk_rs1 awaits load data
- chk_rs2_busy  out  1  chk_rs2 awaits load data
- regwr_en  out  1  register file write enable
- regwr_sel  out  5  register file write select
- regwr_data  out  32  register file write data

## Operation
- Transfer on a requester = vld & rdy in the same cycle. At most one rdy is high per cycle. rdy is combinational from the vld inputs and prio. A requester must hold vld/sel/data stable until accepted.
- Arbitration between EX and LSU is round-robin via a 1-bit prio register: 0 = EX favoured, 1 = LSU favoured.
  - Both valid: the favoured one is granted.
  - One valid: that one is granted.
  - Grant to EX sets prio=1; grant to LSU sets prio=0.
- DBG is granted only when neither EX nor LSU is valid. A DBG grant leaves prio unchanged.
- Write port is registered. On any transfer:
  - regwr_sel and regwr_data load the granted sel/data.
  - regwr_en <= (sel != 0).
  - With no transfer, regwr_en <= 0 and sel/data hold.
  - Writes to x0 are accepted and consumed but never assert regwr_en.
- Scoreboard: 32-bit busy mask; bit 0 is hardwired 0.
  - lsu_issue with rd != 0 sets busy[rd].
  - An LSU transfer clears busy[lsu_wb_sel].
  - Set and clear of the same register in the same cycle: set wins.
  - At most one load is outstanding per register; a re-issue to an already-busy rd leaves it busy.
- chk_rsN_busy = busy[chk_rsN] (combinational from the registered mask). A write in flight on regwr_* is not reported busy; the RF write bypass covers it.

## Timing
- Reset values: regwr_en=0, regwr_sel=0, regwr_data=0, prio=0, busy=0. All rdy outputs are 0 while rstz is low.
- Latency: transfer in cycle N, regwr_en high in cycle N+1. Throughput is one write per cycle.
- Scoreboard latency:
  - lsu_issue in cycle N makes busy visible in cycle N+1.
  - LSU transfer in cycle N clears busy in N+1, the same cycle regwr_en writes the data.
- Reset asserted mid-operation clears busy and drops any pending write; the requesters must re-present after reset.

## Test plan
- Reset: with rstz low, all outputs are 0 and all rdy are 0. After release, ex_wb_vld=1, sel=5, data=0xDEADBEEF -> ex_wb_rdy=1 same cycle; next cycle regwr_en=1, sel=5, data=0xDEADBEEF.
- Contention: EX and LSU both valid for 4 cycles, starting from prio=0 -> grants EX, LSU, EX, LSU; regwr_en high 4 consecutive cycles.
- DBG yields: dbg_wb_vld held with EX valid for 2 cycles -> dbg_wb_rdy=0 for those cycles, 1 in the first cycle EX drops vld; prio unchanged.
- x0 write: EX sel=0, data=0x1234 -> ex_wb_rdy=1, next cycle regwr_en=0.
- Scoreboard: lsu_issue rd=7, then chk_rs1=7 -> busy=1 from the next cycle. LSU transfer sel=7 -> busy=0 one cycle later, with regwr_en=1, sel=7 in that same cycle.
- Same-cycle set and clear: LSU transfer sel=9 together with lsu_issue rd=9 -> busy[9]=1 afterwards. lsu_issue rd=0 -> chk_rs2=0 is never busy.
